pio_edge_debounce_in: RTL and testbench
=======================================

// Module: pio_edge_debounce_in
// PURPOSE
//   Parametrised Avalon-MM input PIO for push-buttons and switches, successor to the fixed 4-bit
//   falling-edge PIO. Adds per-channel synchroniser and debounce, per-bit rising/falling edge select,
//   and write-1-to-clear edge capture. Drives a level IRQ to the Nios II.
//   Sits between the board inputs and the system interconnect.
// PARAMETERS
//   WIDTH            4    number of input channels, 1..32
//   SYNC_STAGES      2    flip-flops in the input synchroniser, >=2
//   DEBOUNCE_CYCLES  16   consecutive cycles a change must hold before it is accepted; 0 = bypass
// PORTS
//   clk         in   1      system clock
//   reset       in   1      synchronous, active-high reset
//   address     in   3      word register select
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe, qualified by chipselect
//   writedata   in   32     write data
//   readdata    out  32     registered read data
//   in_port     in   WIDTH  asynchronous external inputs
//   irq         out  1      level interrupt = |(edge_capture & irq_mask)
// BEHAVIOUR
//   Interface: one clock (clk); reset is synchronous and active-high. All state is cleared on a clk edge
//     while reset=1.
//   Register map (rd/wr). Bits [31:WIDTH] read 0 and are ignored on write.
//     0 data      RO  debounced input value
//     1 raw       RO  synchroniser output
//     2 irq_mask  RW
//     3 edge_cap  R/W1C
//     4 rise_en   RW
//     5 fall_en   RW
//     6,7         read 0, writes ignored.
//   Writes: a write occurs when chipselect & ~write_n. A write to a RO address is ignored.
//   Reads: readdata <= mux(address) on every clk, with 1-cycle latency and no read strobe.
//   Reset values:
//     - readdata, irq_mask, edge_cap, rise_en, synchroniser, counters and stable: 0
//     - fall_en: all ones, which gives the legacy push-button falling-edge behaviour
//     - irq: 0
//   Synchroniser: SYNC_STAGES flops per bit. s = last stage.
//   Debounce, per bit i:
//     - cnt_i is ceil(log2(DEBOUNCE_CYCLES+1)) bits wide.
//     - If s[i]==stable[i]: cnt_i<=0.
//     - Otherwise, if cnt_i==DEBOUNCE_CYCLES-1: stable[i]<=s[i] and cnt_i<=0.
//     - Otherwise: cnt_i<=cnt_i+1.
//     - Any bounce back to the stable value restarts the count. The counter never wraps.
//     - DEBOUNCE_CYCLES=0 gives stable<=s every cycle.
//   Edge detect:
//     - stable_d <= stable.
//     - edge = (stable & ~stable_d & rise_en) | (~stable & stable_d & fall_en).
//     - rise_en = fall_en = 1 gives any-edge detection.
//   Edge capture: edge_cap <= (edge_cap & ~clr) | edge, where clr = writedata[WIDTH-1:0] on a write to
//     address 3, else 0.
//     - If set and clear hit the same bit in the same cycle, set wins, so no event is lost.
//     - Clearing does not affect other bits.
//   Latency: s[i] first differs from stable[i] in cycle t and stays there.
//     - data[i] updates in cycle t+max(DEBOUNCE_CYCLES,1).
//     - edge_cap[i] and irq update 2 cycles after that, since the edge is taken on stable vs stable_d.
//     - From in_port to s: SYNC_STAGES cycles.
//   irq is combinational from edge_cap and irq_mask. Masking a set bit drops irq in the same cycle
//     without clearing edge_cap.
//   Reset mid-operation:
//     - Pending debounce counts and captures are discarded.
//     - Inputs held high across reset re-qualify as a 0->1 change. This is captured only if rise_en is set,
//       which it is not by default.
// TESTING
//   Bench: WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
//   1. Reset; read every address.
//      -> 0,0,0,0,0,0xF at address 5, 0,0. irq=0 throughout.
//   2. in_port[0] 1->0, held.
//      -> data[0]=0 and edge_cap=0x1 at the fixed latency above.
//      -> write irq_mask=0x1 -> irq=1 next cycle.
//   3. in_port[1] toggles every 2 cycles for 20 cycles, then settles.
//      -> no data change and no capture until 4 stable cycles have elapsed, then exactly one capture.
//   4. rise_en=0x4, fall_en=0; in_port[2] pulses 0->1->0 (each held 10 cycles).
//      -> edge_cap[2] set once, on the rise only.
//   5. edge_cap=0x3; write 0x1 to address 3.
//      -> edge_cap=0x2.
//      -> a W1C of bit 0 in the same cycle as a new bit-0 edge leaves bit 0 = 1.
//   6. Assert reset mid-debounce (cnt=2).
//      -> all registers return to reset values; no spurious capture afterwards with default enables.

Source files
------------

// File: rtl/pio_edge_debounce_in.sv
// Avalon-MM input PIO: per-channel synchroniser, debounce, selectable rise/fall edge
// capture with write-1-to-clear, and a level interrupt.
module pio_edge_debounce_in #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [2:0] AddrData  = 3'd0;
    localparam logic [2:0] AddrRaw   = 3'd1;
    localparam logic [2:0] AddrMask  = 3'd2;
    localparam logic [2:0] AddrCap   = 3'd3;
    localparam logic [2:0] AddrRise  = 3'd4;
    localparam logic [2:0] AddrFall  = 3'd5;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rd_sel;
    logic [31:0]      readdata_d;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    // Bits above WIDTH are don't-care on write.
    assign unused_wdata = ^writedata;

    // Input synchroniser chain; s is the last stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
        assign stable_d = s;
    end else begin : g_debounce
        localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

        logic [CntW-1:0] cnt_q [WIDTH];
        logic [CntW-1:0] cnt_d [WIDTH];

        // Per-bit run counter: a change is accepted only after it holds long enough.
        always_comb begin
            stable_d = stable_q;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_d[i] = '0;
                if (s[i] != stable_q[i]) begin
                    if (cnt_q[i] == CntLast) begin
                        stable_d[i] = s[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntW'(1);
                    end
                end
            end
        end

        // Debounce counter registers.
        always_ff @(posedge clk) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= reset ? '0 : cnt_d[i];
            end
        end
    end

    // Edge pulse from stable vs its one-cycle-delayed copy, registered before capture.
    always_comb begin
        edge_d = (stable_q & ~stable_dly_q & rise_q) | (~stable_q & stable_dly_q & fall_q);
    end

    // Register writes and edge capture; a same-cycle set beats a clear.
    always_comb begin
        clr    = '0;
        mask_d = mask_q;
        rise_d = rise_q;
        fall_d = fall_q;
        if (wr_en) begin
            unique case (address)
                AddrMask: mask_d = wdata;
                AddrCap:  clr    = wdata;
                AddrRise: rise_d = wdata;
                AddrFall: fall_d = wdata;
                default:  ;
            endcase
        end
        cap_d = (cap_q & ~clr) | edge_q;
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_sel = '0;
        unique case (address)
            AddrData: rd_sel = stable_q;
            AddrRaw:  rd_sel = s;
            AddrMask: rd_sel = mask_q;
            AddrCap:  rd_sel = cap_q;
            AddrRise: rd_sel = rise_q;
            AddrFall: rd_sel = fall_q;
            default:  rd_sel = '0;
        endcase
        readdata_d = '0;
        readdata_d[WIDTH-1:0] = rd_sel;
    end

    // State registers; fall_en resets to all ones for legacy push-button behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q     <= '0;
            stable_dly_q <= '0;
            edge_q       <= '0;
            cap_q        <= '0;
            mask_q       <= '0;
            rise_q       <= '0;
            fall_q       <= '1;
            readdata     <= '0;
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            edge_q       <= edge_d;
            cap_q        <= cap_d;
            mask_q       <= mask_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            readdata     <= readdata_d;
        end
    end

    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_edge_debounce_in.sv
// Bench for pio_edge_debounce_in: directed scenarios plus random traffic, all checked
// against a window-based reference model of the debounce and capture behaviour.
module tb_pio_edge_debounce_in;

    localparam int W    = 4;
    localparam int SYNC = 2;
    localparam int DC   = 4;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    pio_edge_debounce_in #(
        .WIDTH           (W),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model state (values visible in the current cycle).
    logic [W-1:0] m_s, m_stable, m_prev, m_pend, m_cap, m_mask, m_rise, m_fall;
    logic [31:0]  m_rd;
    logic [W-1:0] in_q [$];
    logic [W-1:0] s_hist [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: predict next state from the rules, then compare DUT outputs.
    task automatic step();
        logic [W-1:0] n_s, n_stable, n_prev, n_pend, n_cap, n_mask, n_rise, n_fall, clr;
        logic [31:0]  n_rd;
        logic         wr;
        bit           hold;
        if (reset) begin
            n_s = '0; n_stable = '0; n_prev = '0; n_pend = '0; n_cap = '0;
            n_mask = '0; n_rise = '0; n_fall = '1; n_rd = '0;
            in_q = {};
            repeat (SYNC - 1) in_q.push_back('0);
            s_hist = {};
        end else begin
            wr = chipselect && !write_n;
            n_rd = '0;
            case (address)
                3'd0: n_rd[W-1:0] = m_stable;
                3'd1: n_rd[W-1:0] = m_s;
                3'd2: n_rd[W-1:0] = m_mask;
                3'd3: n_rd[W-1:0] = m_cap;
                3'd4: n_rd[W-1:0] = m_rise;
                3'd5: n_rd[W-1:0] = m_fall;
                default: n_rd = '0;
            endcase
            clr    = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
            n_mask = (wr && address == 3'd2) ? writedata[W-1:0] : m_mask;
            n_rise = (wr && address == 3'd4) ? writedata[W-1:0] : m_rise;
            n_fall = (wr && address == 3'd5) ? writedata[W-1:0] : m_fall;
            n_cap  = (m_cap & ~clr) | m_pend;
            n_pend = (m_stable & ~m_prev & m_rise) | (~m_stable & m_prev & m_fall);
            n_prev = m_stable;
            // Accept a new level once the last DC synchronised samples all agree on it.
            s_hist.push_back(m_s);
            if (s_hist.size() > DC) void'(s_hist.pop_front());
            n_stable = m_stable;
            if (s_hist.size() == DC) begin
                for (int i = 0; i < W; i++) begin
                    hold = 1'b1;
                    foreach (s_hist[k]) if (s_hist[k][i] != m_s[i]) hold = 1'b0;
                    if (hold && m_s[i] != m_stable[i]) n_stable[i] = m_s[i];
                end
            end
            in_q.push_back(in_port);
            n_s = in_q.pop_front();
        end
        @(posedge clk);
        #1;
        m_s = n_s; m_stable = n_stable; m_prev = n_prev; m_pend = n_pend; m_cap = n_cap;
        m_mask = n_mask; m_rise = n_rise; m_fall = n_fall; m_rd = n_rd;
        chk("model_readdata", readdata, m_rd);
        chk("model_irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    logic [31:0] rst_exp [8];

    initial begin
        rst_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hF, 32'h0, 32'h0};
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0;
        writedata = '0; in_port = '0;

        // 1. Reset and read every address.
        repeat (3) step();
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            step();
            chk($sformatf("reset_read_a%0d", a), readdata, rst_exp[a]);
            chk("reset_irq", {31'b0, irq}, 32'h0);
        end
        // Inputs go high: a rise, not captured with default enables.
        in_port = 4'hF;
        address = 3'd3;
        repeat (12) step();
        chk("idle_high_no_cap", readdata, 32'h0);
        address = 3'd0;
        step();
        chk("idle_high_data", readdata, 32'hF);

        // 2. in_port[0] falls: capture visible on a held read at a fixed latency.
        address = 3'd3;
        in_port = 4'hE;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 8) chk("fall_cap_not_yet", readdata, 32'h0);
            if (k == 9) chk("fall_cap_latency", readdata, 32'h1);
        end
        chk("irq_masked", {31'b0, irq}, 32'h0);
        bus_write(3'd2, 32'h1);
        chk("irq_after_mask", {31'b0, irq}, 32'h1);

        // 3. in_port[1] bounces every 2 cycles, then settles low.
        address = 3'd0;
        for (int c = 0; c < 20; c++) begin
            in_port[1] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
            chk("bounce_data_held", readdata, 32'hE);
        end
        in_port[1] = 1'b0;
        address = 3'd3;
        repeat (12) step();
        chk("bounce_single_cap", readdata, 32'h3);

        // 5a. W1C of bit 0 leaves bit 1.
        bus_write(3'd3, 32'hFFFF_FFF1);
        step();
        chk("w1c_bit0", readdata, 32'h2);
        chk("irq_after_w1c", {31'b0, irq}, 32'h0);

        // 4. Rise-only on bit 2: pulse 0->1->0.
        bus_write(3'd4, 32'h4);
        bus_write(3'd5, 32'h0);
        in_port[2] = 1'b0;
        repeat (10) step();
        in_port[2] = 1'b1;
        repeat (10) step();
        in_port[2] = 1'b0;
        address = 3'd3;
        repeat (12) step();
        chk("rise_only_cap", readdata, 32'h6);
        bus_write(3'd3, 32'h6);
        step();
        chk("clear_all", readdata, 32'h0);

        // 5b. Clear of bit 0 in the same cycle as a new bit-0 capture: set wins.
        bus_write(3'd4, 32'h1);
        in_port[0] = 1'b1;
        repeat (7) step();
        bus_write(3'd3, 32'h1);
        step();
        chk("set_beats_clear", readdata, 32'h1);

        // 6. Reset in the middle of a debounce count.
        in_port[3] = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        for (int a = 2; a < 8; a++) begin
            address = 3'(a);
            step();
            chk($sformatf("rereset_read_a%0d", a), readdata, rst_exp[a]);
            chk("rereset_irq", {31'b0, irq}, 32'h0);
        end
        address = 3'd3;
        repeat (20) step();
        chk("no_spurious_cap", readdata, 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) begin
                bus_write(3'($urandom_range(0, 7)), $urandom);
            end else begin
                chipselect = 1'($urandom_range(0, 1));
                write_n    = 1'b1;
                address    = 3'($urandom_range(0, 7));
                writedata  = $urandom;
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
